mem_port_arbiter: RTL and testbench

//  Shares the single-ported unified memory between two requesters of the multi-cycle CPU core:

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-ported unified memory between instruction
// fetch and data access. Only one transaction is in flight at a time, and each
// one runs through IDLE -> ACCESS -> WAIT -> RESP.
// Grants are combinational and come from IDLE or RESP. All other outputs are
// registered.
// Optional feature: define ARB_ROUND_ROBIN_EN to make contention alternate
// between the two requesters. Without it, data always beats fetch.
module mem_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t     state;
  logic [3:0] lat_cnt;
  logic       owner_d;   // 1 = data port owns the transaction, 0 = fetch
  logic       we_l;      // latched store flag; stores return zero read data
  logic       can_grant;
  logic       pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic       last_d;    // 1 = data was the most recently accepted requester

  // Lone requester wins; on contention the one not served last wins
  always_comb begin
    pick_d = d_req & (~if_req | ~last_d);
  end
`else
  // Fixed priority: data beats fetch whenever it asks
  always_comb begin
    pick_d = d_req;
  end
`endif

  // RESP arbitrates exactly like IDLE so back-to-back requests lose no cycle
  assign can_grant = (state == IDLE) || (state == RESP);

  // Gated by rst_n so the grants also drop to zero while reset is asserted
  assign d_gnt  = rst_n & can_grant & d_req & pick_d;
  assign if_gnt = rst_n & can_grant & if_req & ~pick_d;

  // Transaction sequencer with registered memory strobes and response pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      owner_d   <= 1'b0;
      we_l      <= 1'b0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d    <= 1'b1;
`endif
    end else begin
      // Strobes and pulses last a single cycle unless re-armed below
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE, RESP: begin
          if (d_gnt) begin
            owner_d   <= 1'b1;
            we_l      <= d_we;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b1;
`endif
          end else if (if_gnt) begin
            owner_d   <= 1'b0;
            we_l      <= 1'b0;
            mem_en    <= 1'b1;
            mem_addr  <= if_addr;
            state     <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
          end else begin
            state     <= IDLE;
          end
        end
        ACCESS: begin
          lat_cnt <= 4'(MEM_LAT);
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == 4'd1) begin
            // mem_rdata is valid in this cycle, so it is captured at this edge
            lat_cnt <= '0;
            state   <= RESP;
            if (owner_d) begin
              d_valid <= 1'b1;
              d_rdata <= we_l ? '0 : mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed test of mem_port_arbiter in its default fixed-priority build.
// Two instances are used, one with MEM_LAT=1 and one with MEM_LAT=3. Each has
// a small memory model that returns read data only in its valid cycle and a
// garbage word in every other cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  int          errors = 0;
  int          checks = 0;

  // MEM_LAT=1 instance signals
  logic        if_req, if_gnt, if_valid, d_req, d_we, d_gnt, d_valid, mem_en, mem_we;
  logic [9:0]  if_addr, d_addr, mem_addr;
  logic [31:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  // MEM_LAT=3 instance signals
  logic        if_req3, if_gnt3, if_valid3, d_req3, d_we3, d_gnt3, d_valid3, mem_en3, mem_we3;
  logic [9:0]  if_addr3, d_addr3, mem_addr3;
  logic [31:0] if_rdata3, d_wdata3, d_rdata3, mem_wdata3, mem_rdata3;

  // Memory model state
  logic        wr_valid = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] s0, s1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_valid(if_valid3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_valid(d_valid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  // Fixed memory contents; any address not listed below reads back as its own address
  function automatic logic [31:0] init_word(input logic [9:0] a);
    case (a)
      10'h004: return 32'h20080005;
      10'h008: return 32'h12345678;
      10'h020: return 32'hCAFEF00D;
      10'h021: return 32'h0BADCAFE;
      default: return {22'b0, a};
    endcase
  endfunction

  // One-cycle latency memory: the last store overrides the fixed contents
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_valid <= 1'b1;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
    end
    if (mem_en && !mem_we)
      mem_rdata <= (wr_valid && wr_addr == mem_addr) ? wr_data : init_word(mem_addr);
    else
      mem_rdata <= 32'hBAD0BAD0;
  end

  // Three-cycle latency read pipeline
  always @(posedge clk) begin
    s0         <= (mem_en3 && !mem_we3) ? init_word(mem_addr3) : 32'hBAD0BAD0;
    s1         <= s0;
    mem_rdata3 <= s1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    if_req3 = 0; if_addr3 = '0; d_req3 = 0; d_we3 = 0; d_addr3 = '0; d_wdata3 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", 32'({if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Fetch read: accept at T, mem_en at T+1, valid at T+3
    @(negedge clk); if_req = 1; if_addr = 10'h004; #1;
    chk("fetch_if_gnt", 32'(if_gnt), 32'd1);
    chk("fetch_d_gnt", 32'(d_gnt), 32'd0);
    @(negedge clk); if_req = 0; if_addr = 10'h3FF; #1;
    chk("fetch_mem_en", 32'({mem_en, mem_we}), 32'd2);
    chk("fetch_mem_addr", 32'(mem_addr), 32'h004);
    @(negedge clk); #1;
    chk("fetch_wait_idle", 32'({mem_en, if_valid}), 32'd0);
    @(negedge clk); #1;
    chk("fetch_valid", 32'({if_valid, d_valid}), 32'd2);
    chk("fetch_rdata", if_rdata, 32'h20080005);
    @(negedge clk); #1;
    chk("fetch_pulse_end", 32'(if_valid), 32'd0);
    chk("fetch_rdata_hold", if_rdata, 32'h20080005);

    // Load from 0x100, then issue a store during the load's RESP cycle
    @(negedge clk); d_req = 1; d_we = 0; d_addr = 10'h100; #1;
    chk("load_d_gnt", 32'(d_gnt), 32'd1);
    @(negedge clk); d_req = 0;
    @(negedge clk);
    @(negedge clk); d_req = 1; d_we = 1; d_addr = 10'h100; d_wdata = 32'hDEADBEEF; #1;
    chk("load_valid", 32'(d_valid), 32'd1);
    chk("load_rdata", d_rdata, 32'h00000100);
    chk("store_gnt_in_resp", 32'(d_gnt), 32'd1);
    @(negedge clk); d_req = 0; d_we = 0; d_wdata = 32'h0; #1;
    chk("store_mem_en_we", 32'({mem_en, mem_we, d_valid}), 32'd6);
    chk("store_mem_addr", 32'(mem_addr), 32'h100);
    chk("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("store_strobe_once", 32'({mem_en, mem_we}), 32'd0);
    @(negedge clk); #1;
    chk("store_valid", 32'(d_valid), 32'd1);
    chk("store_rdata_zero", d_rdata, 32'd0);

    // Contention: data wins, fetch is granted in the d_valid cycle
    @(negedge clk); if_req = 1; if_addr = 10'h004; d_req = 1; d_we = 0; d_addr = 10'h100; #1;
    chk("cont_gnts", 32'({d_gnt, if_gnt}), 32'd2);
    @(negedge clk); d_req = 0; #1;
    chk("cont_busy_access", 32'(if_gnt), 32'd0);
    chk("cont_mem_addr", 32'(mem_addr), 32'h100);
    @(negedge clk); #1;
    chk("cont_busy_wait", 32'(if_gnt), 32'd0);
    @(negedge clk); #1;
    chk("cont_d_valid", 32'({d_valid, if_gnt}), 32'd3);
    chk("cont_d_rdata", d_rdata, 32'hDEADBEEF);
    @(negedge clk); if_req = 0; #1;
    chk("cont_fetch_access", 32'({mem_en, d_valid}), 32'd2);
    chk("cont_fetch_addr", 32'(mem_addr), 32'h004);
    @(negedge clk);
    @(negedge clk); #1;
    chk("cont_fetch_valid", 32'(if_valid), 32'd1);
    chk("cont_fetch_rdata", if_rdata, 32'h20080005);
    chk("cont_nonowner_hold", d_rdata, 32'hDEADBEEF);

    // Fetch raised while busy and dropped before a grant leaves no trace
    @(negedge clk); d_req = 1; d_we = 0; d_addr = 10'h008; #1;
    chk("drop_d_gnt", 32'(d_gnt), 32'd1);
    @(negedge clk); d_req = 0; if_req = 1; if_addr = 10'h020; #1;
    chk("drop_busy_no_gnt", 32'(if_gnt), 32'd0);
    @(negedge clk); if_req = 0;
    @(negedge clk); #1;
    chk("drop_d_rdata", d_rdata, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("drop_no_side_effect", 32'({mem_en, if_valid}), 32'd0);
    end

    // Reset during WAIT: outputs clear at once, no stray pulse afterwards
    @(negedge clk); if_req = 1; if_addr = 10'h008; #1;
    chk("rstmid_gnt", 32'(if_gnt), 32'd1);
    @(negedge clk); if_req = 0;
    @(negedge clk); rst_n = 1'b0; if_req = 1; #1;
    chk("rstmid_ctl", 32'({if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we}), 32'd0);
    chk("rstmid_rdata", if_rdata | d_rdata, 32'd0);
    @(negedge clk); if_req = 0; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rstmid_no_stray", 32'({if_valid, d_valid, mem_en}), 32'd0);
    end
    @(negedge clk); if_req = 1; if_addr = 10'h008; #1;
    chk("rstmid_new_gnt", 32'(if_gnt), 32'd1);
    @(negedge clk); if_req = 0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rstmid_new_valid", 32'(if_valid), 32'd1);
    chk("rstmid_new_rdata", if_rdata, 32'h12345678);

    // MEM_LAT=3: load accepted at T gives valid at T+5; a fetch raised during the load waits until T+5
    @(negedge clk); d_req3 = 1; d_we3 = 0; d_addr3 = 10'h020; #1;
    chk("lat3_d_gnt", 32'(d_gnt3), 32'd1);
    @(negedge clk); d_req3 = 0; if_req3 = 1; if_addr3 = 10'h021; #1;
    chk("lat3_mem_en", 32'(mem_en3), 32'd1);
    chk("lat3_busy_gnt", 32'(if_gnt3), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk); #1;
      chk("lat3_wait", 32'({if_gnt3, d_valid3, mem_en3}), 32'd0);
    end
    @(negedge clk); #1;
    chk("lat3_valid", 32'({d_valid3, if_gnt3}), 32'd3);
    chk("lat3_rdata", d_rdata3, 32'hCAFEF00D);
    @(negedge clk); if_req3 = 0; #1;
    chk("lat3_fetch_access", 32'(mem_en3), 32'd1);
    chk("lat3_fetch_addr", 32'(mem_addr3), 32'h021);
    repeat (3) @(negedge clk);
    #1;
    chk("lat3_fetch_early", 32'(if_valid3), 32'd0);
    @(negedge clk); #1;
    chk("lat3_fetch_valid", 32'(if_valid3), 32'd1);
    chk("lat3_fetch_rdata", if_rdata3, 32'h0BADCAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
